// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg
//   Shared definitions for the per-core memory request ports and the bank
//   arbiters: bus widths, bank/core counts and the request-port state
//   encoding.
package gpu_mem_pkg;

   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BANK_W    = 4;
   localparam int unsigned NUM_BANKS = 16;
   localparam int unsigned NUM_CORES = 16;

   // Width of the BUSY-cycle timeout counter
   localparam int unsigned TMO_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } port_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt
//   Saturating BUSY-cycle counter for the core memory port.
//   Ports:
//     clock   in  rising-edge clock
//     reset   in  synchronous, active-high
//     clear   in  restart the count from zero (request accepted)
//     enable  in  count this cycle (port is BUSY)
//     hit     out count has reached TIMEOUT while enabled
module mem_timeout_cnt
   import gpu_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic hit
);

   localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT);

   logic [TMO_W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign hit = enable && (count == LIMIT);

endmodule

// File: rtl/core_mem_port.sv
// core_mem_port
//   Per-core memory request port feeding the shared bank arbiter buses.
//   Accepts one load/store at a time, holds it on the mem_* bus until the
//   addressed bank's arbiter signals finish, then returns the read byte or
//   a write acknowledge on the response handshake.
//   Build option: define CORE_MEM_PORT_TIMEOUT_EN to add a BUSY timeout that
//   returns rsp_err=1; otherwise BUSY waits indefinitely and rsp_err is 0.
//   Ports:
//     clock, reset            clock, synchronous active-high reset
//     req_valid/req_ready     request handshake (ready only in IDLE)
//     req_we/addr/wdata       store flag, {bank, offset} address, store data
//     rsp_valid/rsp_ready     response handshake
//     rsp_rdata, rsp_err      load data (0 for stores/errors), timeout flag
//     mem_read/mem_write      request strobes to every arbiter
//     mem_addr/mem_wdata      held request address/data to every arbiter
//     bank_finish             finish bit for this core from each bank
//     bank_rdata              per-bank read data slice for this core
module core_mem_port
   import gpu_mem_pkg::*;
#(
   parameter int unsigned CORE_ID = 0,
   parameter int unsigned BANKS   = NUM_BANKS,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [BANKS-1:0]          bank_finish,
   input  logic [BANKS*DATA_W-1:0]   bank_rdata
);

   port_state_t       state, state_next;
   logic              accept;
   logic              done;
   logic [BANK_W-1:0] sel;
   logic              finish_sel;
   logic              timeout_hit;

   // mem_addr doubles as the held request address
   assign sel        = mem_addr[ADDR_W-1 -: BANK_W];
   assign finish_sel = bank_finish[sel];

`ifdef CORE_MEM_PORT_TIMEOUT_EN
   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .enable (state == BUSY),
      .hit    (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            // finish wins over a coincident timeout
            if (finish_sel || timeout_hit) begin
               done       = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_rdata <= '0;
      end else if (accept) begin
         mem_read  <= !req_we;
         mem_write <= req_we;
         mem_addr  <= req_addr;
         mem_wdata <= req_wdata;
      end else if (done) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         // mem_read still marks a load at this point; stores/timeouts return 0
         rsp_rdata <= (finish_sel && mem_read) ?
                      bank_rdata[DATA_W*int'(sel) +: DATA_W] : '0;
      end
   end

`ifdef CORE_MEM_PORT_TIMEOUT_EN
   logic rsp_err_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_err_q <= 1'b0;
      end else if (done) begin
         rsp_err_q <= !finish_sel;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_port.sv
module tb_core_mem_port;

   logic         clock;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [11:0]  req_addr;
   logic [7:0]   req_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [7:0]   rsp_rdata;
   logic         rsp_err;
   logic         mem_read;
   logic         mem_write;
   logic [11:0]  mem_addr;
   logic [7:0]   mem_wdata;
   logic [15:0]  bank_finish;
   logic [127:0] bank_rdata;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   core_mem_port #(
      .CORE_ID (0),
      .BANKS   (16),
      .TIMEOUT (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .bank_finish (bank_finish),
      .bank_rdata  (bank_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] rdata, input logic err);
      rsp_t e;
      e.rdata = rdata;
      e.err   = err;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic we, input logic [11:0] addr, input logic [7:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      tick();
      req_valid = 1'b0;
   endtask

   // Response monitor: compares every completed response handshake
   always @(negedge clock) begin
      rsp_t e;
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b, expected no response",
                     rsp_rdata, rsp_err);
         end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
         end
      end
   end

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      rsp_ready   = 1'b1;
      bank_finish = '0;
      bank_rdata  = '0;

      // reset state
      tick();
      tick();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      check("rst_mem_rw",    {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_mem_addr",  {20'd0, mem_addr},  32'd0);
      check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      reset = 1'b0;

      // load 0x3A5 from bank 3, finish two cycles after accept
      push_exp(8'h5C, 1'b0);
      issue(1'b0, 12'h3A5, 8'h00);
      check("ld_mem_read_c1", {31'd0, mem_read},  32'd1);
      check("ld_mem_write",   {31'd0, mem_write}, 32'd0);
      check("ld_mem_addr",    {20'd0, mem_addr},  32'h3A5);
      check("ld_req_ready",   {31'd0, req_ready}, 32'd0);
      tick();
      check("ld_mem_read_c2", {31'd0, mem_read},  32'd1);
      bank_finish = 16'h0008;
      bank_rdata  = {16{8'hA0}};
      bank_rdata[31:24] = 8'h5C;
      tick();
      bank_finish = '0;
      check("ld_mem_read_off", {31'd0, mem_read},  32'd0);
      check("ld_rsp_valid",    {31'd0, rsp_valid}, 32'd1);
      tick();
      check("ld_back_idle",    {31'd0, req_ready}, 32'd1);

      // store 0x710 data 0xE1: foreign bank finish ignored, bank 7 completes
      push_exp(8'h00, 1'b0);
      issue(1'b1, 12'h710, 8'hE1);
      check("st_mem_write", {31'd0, mem_write}, 32'd1);
      check("st_mem_read",  {31'd0, mem_read},  32'd0);
      check("st_mem_wdata", {24'd0, mem_wdata}, 32'hE1);
      check("st_mem_addr",  {20'd0, mem_addr},  32'h710);
      bank_finish = 16'h0004;
      bank_rdata  = {16{8'hFF}};
      tick();
      bank_finish = '0;
      tick();
      check("st_busy_write", {31'd0, mem_write}, 32'd1);
      check("st_busy_rsp",   {31'd0, rsp_valid}, 32'd0);
      bank_finish = 16'h0080;
      tick();
      bank_finish = '0;
      check("st_write_off", {31'd0, mem_write}, 32'd0);
      check("st_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("st_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      tick();

      // load from bank 0 under five cycles of backpressure
      rsp_ready = 1'b0;
      push_exp(8'h81, 1'b0);
      issue(1'b0, 12'h0FF, 8'h00);
      tick();
      bank_rdata  = {16{8'h11}};
      bank_rdata[7:0] = 8'h81;
      bank_finish = 16'h0001;
      tick();
      bank_finish = '0;
      bank_rdata  = '0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 12'h123;
      req_wdata = 8'h99;
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rsp_rdata", {24'd0, rsp_rdata}, 32'h81);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
         tick();
      end
      req_valid = 1'b0;
      check("bp_mem_addr_kept", {20'd0, mem_addr}, 32'h0FF);
      check("bp_mem_rw_low", {30'd0, mem_read, mem_write}, 32'd0);
      rsp_ready = 1'b1;
      check("bp_not_ready_yet", {31'd0, req_ready}, 32'd0);
      tick();
      check("bp_req_ready", {31'd0, req_ready}, 32'd1);
      check("bp_rsp_done",  {31'd0, rsp_valid}, 32'd0);

      // highest bank, 0xF00 -> slice [127:120]
      push_exp(8'h3C, 1'b0);
      issue(1'b0, 12'hF00, 8'h00);
      tick();
      bank_rdata = {16{8'h55}};
      bank_rdata[127:120] = 8'h3C;
      bank_finish = 16'h8000;
      tick();
      bank_finish = '0;
      check("b15_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      tick();

      // no finish: timeout build errors out, default build stays BUSY
`ifdef CORE_MEM_PORT_TIMEOUT_EN
      begin
         int n;
         n = 0;
         push_exp(8'h00, 1'b1);
         issue(1'b0, 12'h200, 8'h00);
         while (!rsp_valid && n < 20) begin
            tick();
            n++;
         end
         check("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("tmo_latency_ok", {31'd0, (n == 8 || n == 9)}, 32'd1);
         tick();
      end
`else
      issue(1'b0, 12'h200, 8'h00);
      for (int i = 0; i < 300; i++) tick();
      check("notmo_mem_read", {31'd0, mem_read},  32'd1);
      check("notmo_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("notmo_reset_idle", {31'd0, req_ready}, 32'd1);
`endif

      // reset during the 3rd BUSY cycle drops the request
      issue(1'b0, 12'h4C0, 8'h00);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_mem_rw",    {30'd0, mem_read, mem_write}, 32'd0);
      check("mid_rst_mem_addr",  {20'd0, mem_addr}, 32'd0);
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      bank_finish = 16'h0010;
      bank_rdata  = {16{8'h77}};
      tick();
      bank_finish = '0;
      tick();
      check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_idle",   {31'd0, req_ready}, 32'd1);

      tick();
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
